// File: rtl/cam_pkg.sv
// Shared types and constants for the 8-entry, 4-bit key CAM control slice.
package cam_pkg;

    localparam int DEPTH = 8;
    localparam int KEY_W = 4;
    localparam int IDX_W = 3;

    // Occupancy value that means "every entry is valid".
    localparam logic [IDX_W:0] FULL_CNT = 4'd8;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } cam_state_e;

    // Occupancy increment that saturates at DEPTH (writes when full overwrite the oldest entry).
    function automatic logic [IDX_W:0] occ_inc(input logic [IDX_W:0] occ);
        if (occ == FULL_CNT) begin
            occ_inc = FULL_CNT;
        end else begin
            occ_inc = occ + 4'd1;
        end
    endfunction

endpackage

// File: rtl/cam_ctrl_lookup.sv
// lookup: comparator array, one equality compare of the search key against every entry.
module lookup
    import cam_pkg::*;
(
    input  key_t             D_look,
    input  key_t             r [DEPTH],
    output logic [DEPTH-1:0] v
);

    // Raw per-entry match; valid qualification happens in the controller.
    always_comb begin
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v[i] = (r[i] == D_look);
        end
    end

endmodule

// File: rtl/cam_ctrl_prio_enc8.sv
// prio_enc8: lowest-set-bit encoder over the DEPTH-bit qualified match vector.
module prio_enc8
    import cam_pkg::*;
(
    input  logic [DEPTH-1:0] vec,
    output logic             hit,
    output idx_t             idx
);

    // Scan from the top down so the lowest set bit is the last one to win; idx is 0 on a miss.
    always_comb begin
        hit = |vec;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: entry storage, round-robin allocation and the request/response FSM of the CAM.
// Optional feature macro: CAM_WRITE_DEDUP_EN (drop writes whose key is already stored and valid).
module cam_ctrl
    import cam_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  key_t             req_key,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output idx_t             rsp_idx,
    output logic [DEPTH-1:0] rsp_mvec,
    input  logic             wr_en,
    output logic             wr_ready,
    input  key_t             wr_key,
    input  logic             clear,
    output logic [IDX_W:0]   occupancy,
    output logic             full,
    output logic             dup_drop
);

    cam_state_e       state_r;
    key_t             key_q;
    key_t             entry_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    idx_t             wr_ptr_r;

    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] qual_s;
    logic             enc_hit_s;
    idx_t             enc_idx_s;
    logic             req_fire_s;
    logic             wr_fire_s;
    logic             dup_s;
    logic             alloc_s;

    lookup u_lookup (
        .D_look (key_q),
        .r      (entry_r),
        .v      (v_s)
    );

    prio_enc8 u_enc (
        .vec (qual_s),
        .hit (enc_hit_s),
        .idx (enc_idx_s)
    );

    assign req_fire_s = req_valid && req_ready;
    // clear beats a simultaneous write.
    assign wr_fire_s  = wr_en && wr_ready && !clear;

`ifdef CAM_WRITE_DEDUP_EN
    // Duplicate detection: does wr_key already sit in a valid entry?
    always_comb begin
        dup_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (entry_r[i] == wr_key)) begin
                dup_s = 1'b1;
            end else begin
                dup_s = dup_s;
            end
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    assign alloc_s = wr_fire_s && !dup_s;

    // Qualify raw matches with valid bits; a clear in the LOOKUP cycle forces a miss.
    always_comb begin
        if (clear) begin
            qual_s = '0;
        end else begin
            qual_s = v_s & valid_r;
        end
    end

    // Entry storage, round-robin write pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            valid_r   <= '0;
            wr_ptr_r  <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            dup_drop  <= 1'b0;
        end else begin
            dup_drop <= wr_fire_s && dup_s;
            if (clear) begin
                valid_r   <= '0;
                wr_ptr_r  <= '0;
                occupancy <= '0;
                full      <= 1'b0;
            end else if (alloc_s) begin
                entry_r[wr_ptr_r] <= wr_key;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + 3'd1;
                occupancy         <= occ_inc(occupancy);
                full              <= (occ_inc(occupancy) == FULL_CNT);
            end
        end
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            key_q     <= '0;
            req_ready <= 1'b1;
            wr_ready  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_mvec  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_fire_s) begin
                        key_q     <= req_key;
                        state_r   <= LOOKUP;
                        req_ready <= 1'b0;
                        wr_ready  <= 1'b0;
                    end
                end
                LOOKUP: begin
                    rsp_valid <= 1'b1;
                    rsp_hit   <= enc_hit_s;
                    rsp_idx   <= enc_idx_s;
                    rsp_mvec  <= qual_s;
                    state_r   <= RESP;
                    wr_ready  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    wr_ready  <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed scenarios plus randomized traffic against a behavioural CAM model.
module tb_cam_ctrl;
    import cam_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_key = 4'd0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic       rsp_hit;
    logic [2:0] rsp_idx;
    logic [7:0] rsp_mvec;
    logic       wr_en = 1'b0;
    logic       wr_ready;
    logic [3:0] wr_key = 4'd0;
    logic       clear = 1'b0;
    logic [3:0] occupancy;
    logic       full;
    logic       dup_drop;

    always #5 clk = ~clk;

    cam_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_mvec(rsp_mvec),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_key(wr_key),
        .clear(clear), .occupancy(occupancy), .full(full), .dup_drop(dup_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model: a ring of 8 slots ----------------
    logic [3:0] m_ent [8];
    bit         m_val [8];
    int         m_ptr;
    bit         m_dup;

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_val[i]) n++;
        return n;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) m_val[i] = 0;
        m_ptr = 0;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_ent[i] = 4'd0;
        m_clear();
        m_dup = 0;
    endtask

    task automatic m_write(input logic [3:0] k);
        m_dup = 0;
`ifdef CAM_WRITE_DEDUP_EN
        for (int i = 0; i < 8; i++) if (m_val[i] && m_ent[i] == k) m_dup = 1;
`endif
        if (!m_dup) begin
            m_ent[m_ptr] = k;
            m_val[m_ptr] = 1;
            m_ptr = (m_ptr + 1) % 8;
        end
    endtask

    task automatic m_search(input logic [3:0] k, output bit hit, output int idx, output logic [7:0] mvec);
        hit = 0; idx = 0; mvec = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_val[i] && m_ent[i] == k) begin
                mvec[i] = 1'b1;
                if (!hit) idx = i;
                hit = 1;
            end
        end
    endtask

    // ---------------- stimulus helpers (inputs change on the falling edge) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_occ(input string tag);
        check({tag, "_occ"}, occupancy, m_occ());
        check({tag, "_full"}, full, (m_occ() == 8) ? 1 : 0);
    endtask

    task automatic do_write(input logic [3:0] k, input bit clr);
        check("wr_ready_idle", wr_ready, 1);
        wr_en = 1'b1; wr_key = k; clear = clr;
        tick();
        wr_en = 1'b0; clear = 1'b0;
        if (clr) begin
            m_clear(); m_dup = 0;
        end else begin
            m_write(k);
        end
        check("dup_drop", dup_drop, m_dup);
        check_occ("wr");
    endtask

    task automatic do_lookup(input logic [3:0] k, input bit with_wr, input logic [3:0] wk,
                             input bit clr_lk, input int hold);
        bit         e_hit;
        int         e_idx;
        logic [7:0] e_mvec;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_key = k;
        if (with_wr) begin
            wr_en = 1'b1; wr_key = wk;
        end
        tick();
        req_valid = 1'b0; wr_en = 1'b0;
        if (with_wr) begin
            m_write(wk);
            check("dup_drop_lk", dup_drop, m_dup);
        end
        check("lk_req_ready", req_ready, 0);
        check("lk_wr_ready", wr_ready, 0);
        check("lk_rsp_valid", rsp_valid, 0);
        m_search(k, e_hit, e_idx, e_mvec);
        if (clr_lk) begin
            clear = 1'b1;
            e_hit = 0; e_idx = 0; e_mvec = 8'h00;
        end
        tick();
        clear = 1'b0;
        if (clr_lk) m_clear();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_hit", rsp_hit, e_hit);
        check("rsp_idx", rsp_idx, e_idx);
        check("rsp_mvec", rsp_mvec, e_mvec);
        check("rsp_wr_ready", wr_ready, 1);
        check_occ("lk");
        for (int c = 0; c < hold; c++) begin
            tick();
            check("hold_valid", rsp_valid, 1);
            check("hold_hit", rsp_hit, e_hit);
            check("hold_idx", rsp_idx, e_idx);
            check("hold_mvec", rsp_mvec, e_mvec);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_req_ready", req_ready, 1);
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        // Reset values
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_idx", rsp_idx, 0);
        check("rst_rsp_mvec", rsp_mvec, 0);
        check("rst_occ", occupancy, 0);
        check("rst_full", full, 0);
        check("rst_dup", dup_drop, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: lookup into an empty CAM misses
        do_lookup(4'h5, 0, 4'h0, 0, 0);

        // 2: duplicates stored twice (or dropped with dedup)
        do_write(4'hA, 0);
        do_write(4'h3, 0);
        do_write(4'hA, 0);
        do_lookup(4'hA, 0, 4'h0, 0, 0);

        // 3: wrap-around overwrites the oldest entry
        do_write(4'h0, 1);
        for (int i = 0; i < 9; i++) do_write(4'(i), 0);
        check("t3_full", full, 1);
        check("t3_occ", occupancy, 8);
        do_lookup(4'h8, 0, 4'h0, 0, 0);
        do_lookup(4'h0, 0, 4'h0, 0, 0);

        // 4: response held for 5 cycles of back-pressure
        do_lookup(4'h4, 0, 4'h0, 0, 5);

        // 5: clear in the LOOKUP cycle forces a miss
        do_write(4'h7, 0);
        do_lookup(4'h7, 0, 4'h0, 1, 0);
        check("t5_occ", occupancy, 0);

        // write and request in the same cycle: lookup sees the new entry
        do_lookup(4'hC, 1, 4'hC, 0, 1);

        // clear together with write: write discarded
        do_write(4'h9, 1);

        // 6: reset while in LOOKUP
        do_write(4'hE, 0);
        req_valid = 1'b1; req_key = 4'hE;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_occ", occupancy, 0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_lookup(4'hE, 0, 4'h0, 0, 0);

        // Randomized traffic
        for (int it = 0; it < 80; it++) begin
            int op;
            logic [3:0] k1, k2;
            op = $urandom_range(0, 5);
            k1 = 4'($urandom_range(0, 7));
            k2 = 4'($urandom_range(0, 7));
            case (op)
                0, 1: do_write(k1, ($urandom_range(0, 9) == 0));
                2:    do_lookup(k1, 0, 4'h0, 0, $urandom_range(0, 2));
                3:    do_lookup(k1, 1, k2, 0, $urandom_range(0, 1));
                4:    do_lookup(k1, 0, 4'h0, ($urandom_range(0, 3) == 0), 0);
                default: do_write(k2, 0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
